// File: rtl/iq_mixer_pkg.sv
// iq_mixer_pkg: shared lock-in sample width and iq_mixer FSM states
package iq_mixer_pkg;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL_I, ST_MUL_Q, ST_DONE} state_t;
endpackage

// File: rtl/iq_mixer_serial_mult.sv
// iq_mixer_serial_mult: unsigned DATA_W x DATA_W shift-add multiplier, one partial product per cycle
module iq_mixer_serial_mult
  import iq_mixer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CNT_W = $clog2(DATA_W);
  logic [2*DATA_W-1:0] a_sh, acc;
  logic [DATA_W-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic run;
  // product and done look one add ahead so the caller can chain the next multiply without a gap
  assign product = acc + (b_sh[0] ? a_sh : '0);
  assign done = run && cnt == CNT_W'(DATA_W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      a_sh <= {{DATA_W{1'b0}}, a};
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      acc  <= product;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
      run  <= !done;
    end
  end
endmodule

// File: rtl/iq_mixer.sv
// iq_mixer: I/Q lock-in mixer on one shared shift-add multiplier; IQ_MIXER_OVERRUN_EN adds a sticky overrun flag
module iq_mixer
  import iq_mixer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     sample,
  input  logic [DATA_W-1:0]     ref_cos,
  input  logic [DATA_W-1:0]     ref_sin,
  output logic                  busy,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   i_out,
  output logic [2*DATA_W-1:0]   q_out,
  output logic                  overrun
);
  localparam int PROD_W = 2 * DATA_W;
  state_t state;
  logic [DATA_W-1:0] s_abs, c_abs, n_abs, s_mag, sin_mag, a_op, b_op;
  logic [PROD_W-1:0] prod, i_mag;
  logic neg_i, neg_q, accept, start, done;
  assign s_abs = sample[DATA_W-1] ? -sample : sample;
  assign c_abs = ref_cos[DATA_W-1] ? -ref_cos : ref_cos;
  assign n_abs = ref_sin[DATA_W-1] ? -ref_sin : ref_sin;
  assign busy = state != ST_IDLE;
  assign accept = in_valid && (state == ST_IDLE || state == ST_DONE);
  // the Q multiply starts on the same edge the I result is captured
  assign start = accept || (state == ST_MUL_I && done);
  assign a_op = accept ? s_abs : s_mag;
  assign b_op = accept ? c_abs : sin_mag;
  iq_mixer_serial_mult #(.DATA_W(DATA_W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_op),
    .b       (b_op),
    .done    (done),
    .product (prod)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      i_mag     <= '0;
      s_mag     <= '0;
      sin_mag   <= '0;
      neg_i     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        s_mag   <= s_abs;
        sin_mag <= n_abs;
        neg_i   <= sample[DATA_W-1] ^ ref_cos[DATA_W-1];
        neg_q   <= sample[DATA_W-1] ^ ref_sin[DATA_W-1];
        state   <= ST_MUL_I;
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end else if (done && state == ST_MUL_I) begin
        i_mag <= prod;
        state <= ST_MUL_Q;
      end else if (done && state == ST_MUL_Q) begin
        i_out     <= neg_i ? -i_mag : i_mag;
        q_out     <= neg_q ? -prod : prod;
        out_valid <= 1'b1;
        state     <= ST_DONE;
      end
    end
  end
`ifdef IQ_MIXER_OVERRUN_EN
  always_ff @(posedge clk)
    overrun <= rst ? 1'b0 : overrun || (in_valid && (state == ST_MUL_I || state == ST_MUL_Q));
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_iq_mixer.sv
// tb_iq_mixer: timeline reference model of the I/Q mixer checked every cycle, plus hand-computed products
module tb_iq_mixer;
  localparam int W = 16;
  localparam int LAT = 2 * W + 1;
`ifdef IQ_MIXER_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [W-1:0] sample = '0, ref_cos = '0, ref_sin = '0;
  logic busy, out_valid, overrun;
  logic [2*W-1:0] i_out, q_out;
  int n_chk = 0, n_fail = 0, n_valid = 0;
  int k = 0, acc_at = 0;
  bit pend = 0, armed = 0, m_valid = 0, m_busy = 0, m_ovr = 0;
  logic [31:0] m_i = '0, m_q = '0, p_i = '0, p_q = '0;

  iq_mixer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .sample    (sample),
    .ref_cos   (ref_cos),
    .ref_sin   (ref_sin),
    .busy      (busy),
    .out_valid (out_valid),
    .i_out     (i_out),
    .q_out     (q_out),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // An accepted sample at edge e yields its products after edge e+2W; the block is busy until edge e+2W+1,
  // where a new strobe is accepted again. Strobes while busy before that are dropped.
  always @(posedge clk) begin
    k++;
    m_valid = 0;
    if (rst) begin
      pend = 0; m_i = '0; m_q = '0; m_ovr = 0; armed = 1;
    end else begin
      if (pend && k == acc_at + 2 * W) begin
        m_i = p_i; m_q = p_q; m_valid = 1;
      end
      if (in_valid && pend && k <= acc_at + 2 * W) m_ovr = m_ovr | OVR_EN;
      else if (in_valid) begin
        pend = 1;
        acc_at = k;
        p_i = 32'(int'($signed(sample)) * int'($signed(ref_cos)));
        p_q = 32'(int'($signed(sample)) * int'($signed(ref_sin)));
      end else if (pend && k > acc_at + 2 * W) pend = 0;
    end
    m_busy = pend;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("i_out", i_out, m_i);
      chk("q_out", q_out, m_q);
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (out_valid) n_valid++;
    end
  end

  task automatic pulse(input logic [W-1:0] s, input logic [W-1:0] c, input logic [W-1:0] n);
    sample = s; ref_cos = c; ref_sin = n; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int exp);
    int n = 0;
    for (int c = 1; c <= 100 && n == 0; c++) begin
      @(negedge clk);
      if (out_valid) n = c;
    end
    chk(nm, n, exp);
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_i", i_out, 0);
    chk("rst_q", q_out, 0);
    chk("rst_ovr", 32'(overrun), 0);
    realign();
    pulse(16'd1000, 16'd16384, -16'sd16384);
    wait_valid("lat_basic", LAT);
    chk("basic_i", i_out, 32'd16384000);
    chk("basic_q", q_out, -32'sd16384000);
    chk("done_busy", 32'(busy), 1);
    realign();
    pulse(16'h8000, 16'h8000, 16'h7fff);
    wait_valid("lat_corner", LAT);
    chk("corner_i", i_out, 32'h4000_0000);
    chk("corner_q", q_out, -32'sd1073709056);
    realign();
    pulse(16'd0, 16'h8000, 16'h1234);
    wait_valid("lat_zero", LAT);
    chk("zero_i", i_out, 0);
    chk("zero_q", q_out, 0);
    realign();
    base = n_valid;
    pulse(16'd100, 16'd200, -16'sd300);
    wait_valid("lat_b2b_a", LAT);
    chk("b2b_a_i", i_out, 32'd20000);
    chk("b2b_a_q", q_out, -32'sd30000);
    sample = -16'sd5; ref_cos = 16'd7; ref_sin = 16'd9; in_valid = 1'b1;
    realign();
    in_valid = 1'b0;
    wait_valid("lat_b2b_b", LAT);
    chk("b2b_b_i", i_out, -32'sd35);
    chk("b2b_b_q", q_out, -32'sd45);
    repeat (40) realign();
    chk("b2b_count", n_valid - base, 2);
    base = n_valid;
    pulse(16'd3, 16'd4, 16'd5);
    repeat (8) realign();
    pulse(16'd7, 16'd7, 16'd7);
    wait_valid("lat_drop", LAT - 9);
    chk("drop_i", i_out, 32'd12);
    chk("drop_q", q_out, 32'd15);
    repeat (40) realign();
    chk("drop_count", n_valid - base, 1);
    chk("drop_ovr", 32'(overrun), 32'(OVR_EN));
    rst = 1'b1;
    realign();
    rst = 1'b0;
    base = n_valid;
    pulse(16'd1234, -16'sd2, 16'd3);
    repeat (19) realign();
    rst = 1'b1;
    realign();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_i", i_out, 0);
    chk("abort_q", q_out, 0);
    repeat (40) realign();
    chk("abort_count", n_valid - base, 0);
    pulse(-16'sd100, 16'd50, -16'sd25);
    wait_valid("lat_after_abort", LAT);
    chk("after_abort_i", i_out, -32'sd5000);
    chk("after_abort_q", q_out, 32'd2500);
    realign();
    for (int c = 0; c < 75000; c++) begin
      sample = 16'($urandom);
      ref_cos = 16'($urandom);
      ref_sin = 16'($urandom);
      if ($urandom_range(0, 15) == 0) sample = 16'h8000;
      if ($urandom_range(0, 15) == 0) ref_cos = 16'h8000;
      in_valid = ($urandom_range(0, 7) == 0);
      realign();
    end
    in_valid = 1'b0;
    repeat (40) realign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
